// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the RV32I core: fetch, decode, execute,
// memory and write-back for one instruction at a time, with a memory-ready timeout.
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       retire,
    output logic       halted,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5,
        S_TRAP    = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_ALU, C_JAL, C_JALR, C_LOAD, C_STORE, C_BRANCH
    } cls_t;

    localparam logic [7:0] TO = 8'(MEM_TIMEOUT);

    state_t     st_q, st_d;
    cls_t       cls_q, cls_d, dec_cls;
    logic [1:0] cause_q, cause_d;
    logic [7:0] cnt_q, cnt_d;
    logic       dec_halt;
    logic       waiting;
    logic       timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= S_FETCH;
            cls_q   <= C_NONE;
            cause_q <= 2'd0;
            cnt_q   <= 8'd0;
        end else begin
            st_q    <= st_d;
            cls_q   <= cls_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        dec_cls  = C_NONE;
        dec_halt = 1'b0;
        case (opcode)
            7'b0110011, 7'b0010011,
            7'b0110111, 7'b0010111: dec_cls = C_ALU;
            7'b1101111: dec_cls = C_JAL;
            7'b0000011: if (funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) dec_cls = C_LOAD;
            7'b0100011: if (funct3 <= 3'd2) dec_cls = C_STORE;
            7'b1100011: if (!(funct3 inside {3'd2, 3'd3})) dec_cls = C_BRANCH;
            7'b1100111: if (funct3 == 3'd0) dec_cls = C_JALR;
            7'b1110011: dec_halt = (funct3 == 3'd0);
            default: ;
        endcase
    end

    assign waiting = (st_q == S_FETCH || st_q == S_MEM) && !mem_ready;
    assign timeout = waiting && (MEM_TIMEOUT != 0) && (cnt_q == TO);

    always_comb begin
        st_d      = st_q;
        cls_d     = cls_q;
        cause_d   = cause_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        retire    = 1'b0;
        halted    = 1'b0;
        trap      = 1'b0;
        unique case (st_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    st_d     = S_DECODE;
                end else if (timeout) begin
                    st_d    = S_TRAP;
                    cause_d = 2'd2;
                end
            end
            S_DECODE: begin
                cls_d = dec_cls;
                if (dec_cls != C_NONE) begin
                    st_d = S_EXECUTE;
                end else if (dec_halt) begin
                    st_d = S_HALT;
                end else begin
                    st_d    = S_TRAP;
                    cause_d = 2'd1;
                end
            end
            S_EXECUTE: begin
                if (cls_q == C_BRANCH) begin
                    pc_write = 1'b1;
                    pc_src   = branch_taken ? 2'd1 : 2'd0;
                    retire   = 1'b1;
                    st_d     = S_FETCH;
                end else if (cls_q == C_LOAD || cls_q == C_STORE) begin
                    st_d = S_MEM;
                end else begin
                    st_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (cls_q == C_STORE);
                if (mem_ready) begin
                    if (cls_q == C_STORE) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                        st_d     = S_FETCH;
                    end else begin
                        st_d = S_WB;
                    end
                end else if (timeout) begin
                    st_d    = S_TRAP;
                    cause_d = 2'd3;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                retire    = 1'b1;
                st_d      = S_FETCH;
                if (cls_q == C_LOAD) wb_sel = 2'd1;
                else if (cls_q == C_JAL || cls_q == C_JALR) wb_sel = 2'd2;
                if (cls_q == C_JAL) pc_src = 2'd1;
                else if (cls_q == C_JALR) pc_src = 2'd2;
            end
            S_HALT: halted = 1'b1;
            S_TRAP: trap = 1'b1;
            default: st_d = S_FETCH;
        endcase
        // Reset overrides every output in the same cycle, not just from the next edge.
        if (rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            addr_sel  = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 2'd0;
            reg_write = 1'b0;
            wb_sel    = 2'd0;
            retire    = 1'b0;
            halted    = 1'b0;
            trap      = 1'b0;
        end
    end

    assign state      = rst ? 3'd0 : st_q;
    assign trap_cause = rst ? 2'd0 : cause_q;

    // Count restarts on every state change; saturates instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (st_d != st_q) cnt_d = 8'd0;
        else if (waiting && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory access and write-back for one instruction at a time. It takes `opcode`/`funct3` from the instruction field parser on the latched instruction register and drives the datapath enables and muxes. It also enforces a memory-ready timeout and stops in sticky HALT or TRAP states.

## Interface

Parameters:
- `MEM_TIMEOUT`, 255: maximum consecutive un-ready cycles in a memory wait; 0 disables the timeout; counter width is 8 bits.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  7  `instruction[6:0]` of the IR, from the parser.
- `funct3`  in  3  `instruction[14:12]` of the IR, from the parser.
- `mem_ready`  in  1  memory acknowledge; valid only while `mem_req`=1.
- `branch_taken`  in  1  ALU compare result; valid in EXECUTE.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  store strobe; qualified by `mem_req`.
- `addr_sel`  out  1  memory address source: 0 = PC, 1 = ALU result.
- `ir_write`  out  1  latch the fetched word into the IR.
- `pc_write`  out  1  update the PC.
- `pc_src`  out  2  PC source: 0 = PC+4, 1 = PC+imm, 2 = ALU result with bit 0 cleared.
- `reg_write`  out  1  register file write enable (the regfile ignores x0).
- `wb_sel`  out  2  write-back source: 0 = ALU, 1 = load data, 2 = PC+4.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `halted`  out  1  sticky; set by ECALL/EBREAK.
- `trap`  out  1  sticky error flag.
- `trap_cause`  out  2  1 = illegal instruction, 2 = fetch timeout, 3 = data timeout.
- `state`  out  3  debug encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5, TRAP=6.

## Operation

- Outputs are decoded combinationally from `state`, the registered class, `mem_ready` and `branch_taken`. Every output not named in a state is 0.
- **Reset:** while `rst`=1 every output is forced to 0, including `state`. On the first edge the registers clear: `state`=FETCH, class cleared, timeout counter cleared, `trap_cause`=0.
- **FETCH:** `mem_req`=1, `addr_sel`=0.
  - If `mem_ready`=1: `ir_write`=1, next state DECODE.
- **DECODE** (1 cycle): classify `opcode`/`funct3` and register the class. Legal encodings:
  - R 0110011, I-ALU 0010011, LUI 0110111, AUIPC 0010111 and JAL 1101111: any `funct3`.
  - LOAD 0000011: `funct3` in {0,1,2,4,5}.
  - STORE 0100011: `funct3` in {0,1,2}.
  - BRANCH 1100011: `funct3` not in {2,3}.
  - JALR 1100111: `funct3`=0.
  - SYSTEM 1110011 with `funct3`=0 goes to HALT.
  - Anything else goes to TRAP with cause 1.
- **EXECUTE** (1 cycle):
  - BRANCH: `pc_write`=1, `pc_src` = `branch_taken` ? 1 : 0, `retire`=1, next FETCH.
  - LOAD/STORE: next MEM.
  - All other classes: next WRITEBACK.
- **MEM:** `mem_req`=1, `addr_sel`=1, `mem_we` = (class==STORE).
  - STORE with `mem_ready`=1: `pc_write`=1, `pc_src`=0, `retire`=1, next FETCH.
  - LOAD with `mem_ready`=1: next WRITEBACK.
- **WRITEBACK** (1 cycle): `reg_write`=1, `pc_write`=1, `retire`=1, next FETCH.
  - `wb_sel`: LOAD=1; JAL/JALR=2; otherwise 0.
  - `pc_src`: JAL=1; JALR=2; otherwise 0.
- **HALT / TRAP:** absorbing; only `rst` exits.
  - All strobes are 0; `halted` / `trap` = 1.
  - `trap_cause` is held.
- **Timeout counter:**
  - Cleared on entry to FETCH or MEM.
  - Increments on each wait-state cycle with `mem_ready`=0.
  - When the count equals `MEM_TIMEOUT` and `mem_ready`=0, next state is TRAP with cause 2 (FETCH) or 3 (MEM). `mem_req` drops the following cycle.
  - `mem_ready`=1 in the limit cycle completes normally; ready always wins.
  - The counter saturates, never wraps.

## Timing

- `mem_ready` is accepted in the same cycle `mem_req` is high; zero-wait memory adds no extra cycles.
- Cycles per instruction with zero-wait memory:
  - BRANCH: 3.
  - STORE: 4.
  - ALU, LUI, AUIPC, JAL, JALR: 4.
  - LOAD: 5.
  - Each wait cycle adds 1.
- `retire` rises in the same cycle as the final `pc_write`; exactly one pulse per instruction.
- `mem_ready` outside FETCH/MEM is ignored.
- `rst` asserted mid-instruction, including during a pending memory wait, returns to FETCH on the next edge. No `retire`, `reg_write` or `pc_write` is issued for the aborted instruction.
- `MEM_TIMEOUT`=0: waits indefinitely.

## Test plan

- **ADD, zero-wait memory:** `opcode`=0110011 → states 0,1,2,4. WRITEBACK has `reg_write`=1, `wb_sel`=0, `pc_src`=0, `retire`=1; 4 cycles total.
- **LW with 3 wait cycles in MEM:** `opcode`=0000011, `funct3`=2 → `mem_req`/`addr_sel`=1 for 4 cycles, then WRITEBACK with `wb_sel`=1; 8 cycles total.
- **BEQ:** with `branch_taken`=1 → `pc_src`=1 in EXECUTE, 3 cycles. With `branch_taken`=0 → `pc_src`=0. SW `funct3`=2 → `mem_we`=1 in MEM, no `reg_write`.
- **Illegal opcode:** `opcode`=0001011 in DECODE → `trap`=1, `trap_cause`=1, `state`=6, held for 20 cycles. `rst` pulse → FETCH with `mem_req`=1.
- **Fetch timeout:** `MEM_TIMEOUT`=4 and `mem_ready` stuck at 0 → TRAP cause 2 after 5 FETCH cycles. Same setup with `mem_ready`=1 in the 5th cycle → DECODE instead.
- **ECALL and mid-access reset:** `opcode`=1110011, `funct3`=0 → `halted`=1 and all strobes 0. Separately, `rst`=1 during a MEM wait → FETCH next cycle, no `retire`.
